// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default PC/stack sizing and the control-priority
// action codes used by the control unit and the PC/stack unit.
package cpu_pkg;

  localparam int unsigned PC_W         = 8;
  localparam int unsigned RSTACK_DEPTH = 4;

  // Action codes, one per falling edge, listed lowest to highest priority
  localparam logic [2:0] ACT_HOLD  = 3'd0;
  localparam logic [2:0] ACT_INC   = 3'd1;
  localparam logic [2:0] ACT_JUMP  = 3'd2;
  localparam logic [2:0] ACT_RET   = 3'd3;
  localparam logic [2:0] ACT_CALL  = 3'd4;
  localparam logic [2:0] ACT_STALL = 3'd5;

  // Resolve simultaneous control requests to the single winning action
  function automatic logic [2:0] prio_decode(input logic stall, input logic call,
                                             input logic ret, input logic jump,
                                             input logic inc);
    if (stall)     return ACT_STALL;
    else if (call) return ACT_CALL;
    else if (ret)  return ACT_RET;
    else if (jump) return ACT_JUMP;
    else if (inc)  return ACT_INC;
    else           return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control/status bundle between the control unit (master) and the PC unit (slave).
interface pc_stack_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned AW    = PC_W,
  parameter int unsigned DEPTH = RSTACK_DEPTH
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic          stall;
  logic          inc;
  logic          jump;
  logic          call;
  logic          ret;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic [SPW-1:0] sp;
  logic          stack_full;
  logic          stack_empty;
  logic          ovf;
  logic          udf;

  modport master (
    output stall, inc, jump, call, ret, target,
    input  pc, sp, stack_full, stack_empty, ovf, udf
  );

  modport slave (
    input  stall, inc, jump, call, ret, target,
    output pc, sp, stack_full, stack_empty, ovf, udf
  );

endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address LIFO: DEPTH x AW storage plus an occupancy counter.
// Updates on the falling edge; push into a full stack or pop of an empty
// stack leaves it unchanged, with no error reporting here.
module pc_ret_stack #(
  parameter  int unsigned AW    = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  din,
  output logic [AW-1:0]  top,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);

  logic [AW-1:0] mem [DEPTH];

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);

  // Occupancy counter; push wins if both are asserted
  always_ff @(negedge clk) begin
    if (rst)
      sp <= '0;
    else if (push && !full)
      sp <= sp + SPW'(1);
    else if (pop && !empty)
      sp <= sp - SPW'(1);
  end

  // Write the pushed address into the slot just above the current top
  always_ff @(negedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!rst && push && !full && sp == SPW'(i))
        mem[i] <= din;
    end
  end

  // Top-of-stack is the entry at sp-1; reads as zero when empty
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp == SPW'(i + 1))
        top = mem[i];
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter unit with hardware return-address stack, stall and sticky
// overflow/underflow flags. All state changes on the falling edge of clk.
module pc_stack_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AW    = PC_W,
  parameter int unsigned DEPTH = RSTACK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  pc_stack_unit_if.slave   bus
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic [2:0]     act;
  logic [AW-1:0]  pc_q;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  top;
  logic [SPW-1:0] sp;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           ovf_q;
  logic           udf_q;

  assign pc_inc = pc_q + AW'(1);

  // Single winning action this edge; reset suppresses every request
  always_comb begin
    act = ACT_HOLD;
    if (!rst)
      act = prio_decode(bus.stall, bus.call, bus.ret, bus.jump, bus.inc);
  end

  assign push = (act == ACT_CALL) && !full;
  assign pop  = (act == ACT_RET)  && !empty;

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  // Program counter update
  always_ff @(negedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      case (act)
        ACT_CALL: if (!full)  pc_q <= bus.target;
        ACT_RET:  if (!empty) pc_q <= top;
        ACT_JUMP: pc_q <= bus.target;
        ACT_INC:  pc_q <= pc_inc;
        default:  ;
      endcase
    end
  end

  // Sticky stack-error flags, cleared only by reset
  always_ff @(negedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (act == ACT_CALL && full)
        ovf_q <= 1'b1;
      if (act == ACT_RET && empty)
        udf_q <= 1'b1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;

endmodule
